// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, one-word-per-line instruction cache that sits
// between the fetch stage and the memory arbiter's fetcher port.
// Hits answer one cycle after the request. A miss issues a single word read,
// fills the line and then returns the word. A rollback abandons any
// outstanding request and leaves the array untouched.
module icache_direct #(
    parameter int INDEX_WIDTH = 8,
    parameter int ADDR_WIDTH  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_rollback,
    input  logic        in_fetcher_ena,
    input  logic [31:0] in_fetcher_addr,
    output logic        out_fetcher_ok,
    output logic [31:0] out_fetcher_data,
    output logic        out_mem_ena,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ok,
    input  logic [31:0] in_mem_data
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - 2 - INDEX_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MISS = 1'b1
    } state_t;

    state_t                 r_state;
    logic [LINES-1:0]       r_valid;
    logic [TAG_WIDTH-1:0]   r_tag  [LINES];
    logic [31:0]            r_data [LINES];

    // Lookup side: fields of the incoming PC.
    logic [INDEX_WIDTH-1:0] w_req_index;
    logic [TAG_WIDTH-1:0]   w_req_tag;
    logic                   w_hit;
    logic [31:0]            w_hit_data;

    // Fill side: fields of the pending miss address. out_mem_addr doubles as
    // the latched miss PC because it is held stable for the whole miss.
    logic [INDEX_WIDTH-1:0] w_fill_index;
    logic [TAG_WIDTH-1:0]   w_fill_tag;
    logic                   w_fill_we;

    // The byte offset of the PC never matters for a word fetch.
    logic                   w_unused_addr_bits;

    assign w_req_index = in_fetcher_addr[INDEX_WIDTH+1:2];
    assign w_req_tag   = in_fetcher_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign w_hit       = r_valid[w_req_index] && (r_tag[w_req_index] == w_req_tag);
    assign w_hit_data  = r_data[w_req_index];

    assign w_fill_index = out_mem_addr[INDEX_WIDTH+1:2];
    assign w_fill_tag   = out_mem_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];

    // A fill happens only when memory answers while a miss is still wanted:
    // reset, a stall or a same-cycle rollback all discard the returned word.
    assign w_fill_we = rst && ena && !in_rollback && (r_state == ST_MISS) && in_mem_ok;

    assign w_unused_addr_bits = ^in_fetcher_addr[1:0];

    // Tag/data array write port; no reset so it can map onto plain RAM,
    // line validity is tracked separately in r_valid.
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= in_mem_data;
        end else begin
            r_tag[w_fill_index]  <= r_tag[w_fill_index];
            r_data[w_fill_index] <= r_data[w_fill_index];
        end
    end

    // Control FSM with registered fetcher and memory-side outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid          <= '0;
            r_state          <= ST_IDLE;
            out_fetcher_ok   <= 1'b0;
            out_fetcher_data <= 32'h0000_0000;
            out_mem_ena      <= 1'b0;
            out_mem_addr     <= 32'h0000_0000;
        end else if (ena) begin
            if (in_rollback) begin
                // Flush: drop any new request and any returning word.
                r_state        <= ST_IDLE;
                out_mem_ena    <= 1'b0;
                out_fetcher_ok <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        out_fetcher_ok <= 1'b0;
                        if (in_fetcher_ena) begin
                            if (w_hit) begin
                                out_fetcher_ok   <= 1'b1;
                                out_fetcher_data <= w_hit_data;
                            end else begin
                                out_mem_ena  <= 1'b1;
                                out_mem_addr <= {in_fetcher_addr[31:2], 2'b00};
                                r_state      <= ST_MISS;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_MISS: begin
                        // New fetcher requests are not expected here and
                        // are ignored until the miss completes.
                        out_fetcher_ok <= 1'b0;
                        if (in_mem_ok) begin
                            r_valid[w_fill_index] <= 1'b1;
                            out_fetcher_ok        <= 1'b1;
                            out_fetcher_data      <= in_mem_data;
                            out_mem_ena           <= 1'b0;
                            r_state               <= ST_IDLE;
                        end else begin
                            r_state <= ST_MISS;
                        end
                    end
                    default: begin
                        r_state        <= ST_IDLE;
                        out_fetcher_ok <= 1'b0;
                        out_mem_ena    <= 1'b0;
                    end
                endcase
            end
        end else begin
            r_state <= r_state;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: a behavioural cache model predicts
// hit/miss per request, a memory responder serves misses, and a monitor
// compares every consumed ok pulse against the expected-data queue.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst, ena, in_fetcher_ena, in_mem_ok;
    logic        rb_drv = 1'b0, rb_mem = 1'b0;
    logic        in_rollback;
    logic [31:0] in_fetcher_addr, in_mem_data;
    logic        out_fetcher_ok, out_mem_ena;
    logic [31:0] out_fetcher_data, out_mem_addr;

    assign in_rollback = rb_drv | rb_mem;

    always #5 clk = ~clk;

    icache_direct #(.INDEX_WIDTH(8), .ADDR_WIDTH(18)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
        .in_fetcher_ena(in_fetcher_ena), .in_fetcher_addr(in_fetcher_addr),
        .out_fetcher_ok(out_fetcher_ok), .out_fetcher_data(out_fetcher_data),
        .out_mem_ena(out_mem_ena), .out_mem_addr(out_mem_addr),
        .in_mem_ok(in_mem_ok), .in_mem_data(in_mem_data)
    );

    int vectors = 0, miscompares = 0;
    int ok_count = 0, mem_done_cnt = 0;
    int mem_lat = -1;
    bit rb_with_ok = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] miss_q[$];

    // Reference cache state: 256 lines, 8-bit tag (PC bits 17:10).
    bit          mvalid[256];
    logic [7:0]  mtag[256];
    logic [31:0] mdata[256];
    logic [31:0] mem_over[int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %h, expected none", name, act);
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        int unsigned k;
        k = int'(a[17:2]);
        if (mem_over.exists(k)) return mem_over[k];
        return (k * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Monitor: an ok pulse is consumed at a posedge where ena is high.
    always @(negedge clk) begin
        if (rst === 1'b1 && ena === 1'b1 && out_fetcher_ok === 1'b1) begin
            ok_count++;
            if (exp_q.size() == 0) fail("unexpected_ok", out_fetcher_data);
            else check("ok_data", out_fetcher_data, exp_q.pop_front());
        end
    end

    // Memory responder: checks each word read address and answers it.
    initial begin
        in_mem_ok   = 1'b0;
        in_mem_data = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && out_mem_ena === 1'b1) begin
                logic [31:0] a;
                int          lat;
                bit          abort, rb;
                a     = out_mem_addr;
                abort = 1'b0;
                rb    = rb_with_ok;
                if (miss_q.size() == 0) fail("unexpected_mem_req", a);
                else check("mem_addr", a, miss_q.pop_front());
                lat = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
                for (int i = 0; i < lat; i++) begin
                    @(posedge clk);
                    if (rst !== 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                end
                if (!abort) begin
                    #1;
                    in_mem_data = mem_val(a);
                    in_mem_ok   = 1'b1;
                    rb_mem      = rb;
                    forever begin
                        @(posedge clk);
                        if (rst !== 1'b1) begin
                            abort = 1'b1;
                            break;
                        end
                        if (ena === 1'b1) break;
                    end
                    #1;
                    in_mem_ok   = 1'b0;
                    rb_mem      = 1'b0;
                    in_mem_data = $urandom;
                    if (!abort) begin
                        @(negedge clk);
                        check("ok_after_fill", {31'h0, out_fetcher_ok}, rb ? 32'h0 : 32'h1);
                        check("mem_ena_dropped", {31'h0, out_mem_ena}, 32'h0);
                        mem_done_cnt++;
                    end
                end
            end
        end
    end

    // Issue one request; the model decides hit/miss and queues expectations.
    task automatic req(input logic [31:0] pc, input bit rb, input bit chk_lat);
        int          idx;
        logic [7:0]  tg;
        bit          hit;
        logic [31:0] w;
        int          tgt_ok, tgt_mem, waited;
        idx     = int'(pc[9:2]);
        tg      = pc[17:10];
        hit     = mvalid[idx] && (mtag[idx] == tg);
        w       = {pc[31:2], 2'b00};
        tgt_ok  = ok_count + (rb ? 0 : 1);
        tgt_mem = mem_done_cnt + 1;
        waited  = 0;
        if (rb) begin
            miss_q.push_back(w);
            rb_with_ok = 1'b1;
        end else if (hit) begin
            exp_q.push_back(mdata[idx]);
        end else begin
            miss_q.push_back(w);
            exp_q.push_back(mem_val(w));
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            mdata[idx]  = mem_val(w);
        end
        in_fetcher_addr = {pc[31:2], 2'($urandom)};
        in_fetcher_ena  = 1'b1;
        sync();
        in_fetcher_ena  = 1'b0;
        in_fetcher_addr = $urandom;
        while (rb ? (mem_done_cnt < tgt_mem) : (ok_count < tgt_ok)) begin
            if (waited >= 200) begin
                fail("req_timeout", pc);
                break;
            end
            @(posedge clk);
            waited++;
        end
        #1;
        rb_with_ok = 1'b0;
        if (hit && !rb && chk_lat) check("hit_latency", waited, 32'd1);
    endtask

    task automatic hit_nowait(input logic [31:0] pc);
        exp_q.push_back(mdata[int'(pc[9:2])]);
        in_fetcher_addr = pc;
        in_fetcher_ena  = 1'b1;
        sync();
        in_fetcher_ena  = 1'b0;
    endtask

    task automatic wait_ok(input int tgt);
        int waited;
        waited = 0;
        while (ok_count < tgt) begin
            if (waited >= 200) begin
                fail("ok_timeout", ok_count);
                break;
            end
            @(posedge clk);
            waited++;
        end
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ok"},       {31'h0, out_fetcher_ok}, 32'h0);
        check({tag, "_data"},     out_fetcher_data,        32'h0);
        check({tag, "_mem_ena"},  {31'h0, out_mem_ena},    32'h0);
        check({tag, "_mem_addr"}, out_mem_addr,            32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tgt;
        mem_over[32'h0000]  = 32'h0000_0413;
        mem_over[32'h0001]  = 32'hAAAA_0001;
        mem_over[32'h0101]  = 32'hBBBB_0002;
        mem_over[32'h0040]  = 32'hDEAD_BEEF;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;

        // Reset with ena low: reset still wins.
        rst = 1'b0; ena = 1'b0; in_fetcher_ena = 1'b0; in_fetcher_addr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        sync();
        rst = 1'b1; ena = 1'b1;
        sync();

        // Cold miss, then hits.
        mem_lat = 3;
        req(32'h0000_0000, 1'b0, 1'b1);
        mem_lat = -1;
        req(32'h0000_0000, 1'b0, 1'b1);
        tgt = ok_count + 3;
        hit_nowait(32'h0000_0000);
        hit_nowait(32'h0000_0000);
        hit_nowait(32'h0000_0000);
        wait_ok(tgt);

        // Conflict eviction on index 1.
        req(32'h0000_0004, 1'b0, 1'b1);
        req(32'h0000_0404, 1'b0, 1'b1);
        req(32'h0000_0004, 1'b0, 1'b1);

        // Rollback coincident with the memory answer: nothing filled.
        req(32'h0000_0100, 1'b1, 1'b0);
        req(32'h0000_0100, 1'b0, 1'b1);

        // Rollback right after a hit: hit ok survives, new request dropped.
        tgt = ok_count + 1;
        hit_nowait(32'h0000_0000);
        rb_drv = 1'b1; in_fetcher_ena = 1'b1; in_fetcher_addr = 32'h0000_0800;
        sync();
        rb_drv = 1'b0; in_fetcher_ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rb_no_ok", {31'h0, out_fetcher_ok}, 32'h0);
            check("rb_no_mem", {31'h0, out_mem_ena}, 32'h0);
        end
        check("hit_before_rollback", ok_count, tgt);
        sync();

        // Stall during a miss.
        mem_lat = 2;
        fork
            req(32'h0000_0208, 1'b0, 1'b0);
            begin
                @(posedge clk); @(posedge clk); #1; ena = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_mem_ena", {31'h0, out_mem_ena}, 32'h1);
                    check("stall_mem_addr", out_mem_addr, 32'h0000_0208);
                    check("stall_miss_ok", {31'h0, out_fetcher_ok}, 32'h0);
                end
                @(posedge clk); #1; ena = 1'b1;
            end
        join
        mem_lat = -1;

        // Stall while a hit ok is pending.
        fork
            req(32'h0000_0208, 1'b0, 1'b0);
            begin
                @(posedge clk); #1; ena = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_ok", {31'h0, out_fetcher_ok}, 32'h1);
                    check("stall_data", out_fetcher_data, mem_val(32'h0000_0208));
                end
                @(posedge clk); #1; ena = 1'b1;
            end
        join
        @(negedge clk);
        check("single_pulse", {31'h0, out_fetcher_ok}, 32'h0);
        sync();

        // Randomized traffic over a few aliasing lines.
        for (int n = 0; n < 150; n++) begin
            logic [31:0] pc;
            logic [7:0]  ix, tg;
            logic [13:0] up;
            bit          hit, rbf;
            ix  = 8'h40 + 8'($urandom_range(0, 3));
            tg  = 8'($urandom_range(0, 2));
            up  = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'h0;
            pc  = {up, tg, ix, 2'($urandom)};
            hit = mvalid[int'(ix)] && (mtag[int'(ix)] == tg);
            rbf = !hit && ($urandom_range(0, 7) == 0);
            req(pc, rbf, 1'b1);
        end

        // Reset in the middle of a miss.
        mem_lat = 20;
        miss_q.push_back(32'h0000_2000);
        in_fetcher_addr = 32'h0000_2000; in_fetcher_ena = 1'b1;
        sync();
        in_fetcher_ena = 1'b0;
        repeat (3) sync();
        check("premiss_mem_ena", {31'h0, out_mem_ena}, 32'h1);
        rst = 1'b0;
        sync();
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("midreset");
        sync();
        mem_lat = -1;
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        req(32'h0000_0000, 1'b0, 1'b1);
        req(32'h0000_0000, 1'b0, 1'b1);

        repeat (5) sync();
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("miss_q_drained", miss_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
